fetch_stage: RTL

Instruction fetch stage that sits directly upstream of the decode logic and the immediate sign-extension unit. It holds the program counter, requests words from instruction memory, and latches each returned instruction into a decode-facing register. It also splits the instruction into fixed MIPS fields, with `id_imm[15:0]` feeding the 16-bit immediate input of the sign extender. A valid/ready handshake toward decode and a branch redirect path are included.

---
 rtl/fetch_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage in front of decode and the immediate
// sign extender. Holds the PC, requests words from instruction memory, and
// latches each returned word into a decode-facing register. A valid/ready
// handshake goes toward decode, and a redirect path comes from execute.
// Optional feature macro: FETCH_HALT_EN. When it is defined, fetching HALT_WORD
// parks the stage in HALT until the next reset.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm,
    output logic        halted
);

`ifdef FETCH_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] instr_q,  instr_d;
    logic [31:0] pc4_q,    pc4_d;
    logic        valid_q,  valid_d;
    logic        halted_q, halted_d;
    logic        halt_hit;

    // A returned word is the halt encoding only when the feature is built in.
    assign halt_hit = HALT_EN && (imem_rdata == HALT_WORD);

    // Next-state logic: redirect beats any response or decode acceptance.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (branch_taken) begin
                    pc_d    = branch_target & ~32'h3;
                    valid_d = 1'b0;
                end else if (imem_valid && halt_hit) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (imem_valid) begin
                    instr_d = imem_rdata;
                    pc4_d   = pc_q + 32'd4;
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_target & ~32'h3;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (id_ready) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = state_q;  // HALT: left only by reset
        endcase
    end

    // State and decode register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            pc4_q    <= 32'h0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign id_valid  = valid_q;
    assign id_instr  = instr_q;
    assign id_pc4    = pc4_q;
    assign halted    = halted_q;

    assign id_opcode = instr_q[31:26];
    assign id_rs     = instr_q[25:21];
    assign id_rt     = instr_q[20:16];
    assign id_rd     = instr_q[15:11];
    assign id_shamt  = instr_q[10:6];
    assign id_funct  = instr_q[5:0];
    assign id_imm    = instr_q[15:0];

endmodule
